// File: rtl/i4003x.sv
// Bidirectional serial/parallel shift register with CP-strobe shifting, parallel load and counted bursts.
// Optional macro I4003X_CP_SYNC_EN inserts a 2-flop synchroniser ahead of the CP edge detector.
module i4003x #(
    parameter int WIDTH = 10,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic             CP_i,
    input  logic             DATA_IN_i,
    input  logic             DIR_i,
    input  logic             LOAD_i,
    input  logic [WIDTH-1:0] D_i,
    input  logic             BURST_i,
    input  logic [LEN_W-1:0] BURST_LEN_i,
    input  logic             E_i,
    output logic [WIDTH-1:0] Q_o,
    output logic             SERIAL_OUT_o,
    output logic             BUSY_o,
    output logic             DONE_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] reg_r, reg_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;
    logic             done_r, done_s;
    logic             cp_prev_r;
    logic             cp_s;
    logic             cp_edge_s;

    // One-stage move; the bit leaving the exit end is dropped.
    function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] cur,
                                                  input logic dir, input logic din);
        if (dir) begin
            return {din, cur[WIDTH-1:1]};
        end else begin
            return {cur[WIDTH-2:0], din};
        end
    endfunction

`ifdef I4003X_CP_SYNC_EN
    logic cp_meta_r, cp_sync_r;

    // Two-flop synchroniser for the asynchronous CP strobe
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            cp_meta_r <= 1'b0;
            cp_sync_r <= 1'b0;
        end else begin
            cp_meta_r <= CP_i;
            cp_sync_r <= cp_meta_r;
        end
    end

    assign cp_s = cp_sync_r;
`else
    assign cp_s = CP_i;
`endif

    assign cp_edge_s = cp_s & ~cp_prev_r;

    // Next-state: load beats burst, burst beats CP; CP edges while busy are dropped
    always_comb begin
        state_s = state_r;
        reg_s   = reg_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        if (LOAD_i) begin
            reg_s   = D_i;
            cnt_s   = CNT_ZERO;
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_BURST: begin
                    reg_s = shift_fn(reg_r, DIR_i, DATA_IN_i);
                    cnt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_BURST;
                    end
                end
                ST_IDLE: begin
                    if (BURST_i) begin
                        if (BURST_LEN_i == CNT_ZERO) begin
                            done_s = 1'b1;
                        end else begin
                            cnt_s   = BURST_LEN_i;
                            state_s = ST_BURST;
                        end
                    end else if (cp_edge_s) begin
                        reg_s = shift_fn(reg_r, DIR_i, DATA_IN_i);
                    end else begin
                        reg_s = reg_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State registers; CP history tracks every cycle so no shift is ever deferred
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_r   <= ST_IDLE;
            reg_r     <= {WIDTH{1'b0}};
            cnt_r     <= CNT_ZERO;
            done_r    <= 1'b0;
            cp_prev_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            reg_r     <= reg_s;
            cnt_r     <= cnt_s;
            done_r    <= done_s;
            cp_prev_r <= cp_s;
        end
    end

    assign Q_o          = E_i ? reg_r : {WIDTH{1'b0}};
    assign SERIAL_OUT_o = DIR_i ? reg_r[0] : reg_r[WIDTH-1];
    assign BUSY_o       = (state_r == ST_BURST);
    assign DONE_o       = done_r;

endmodule

// File: tb/tb_i4003x.sv
// Self-checking bench for i4003x: directed scenarios plus randomized traffic against an arithmetic model.
module tb_i4003x;

    localparam int W   = 10;
    localparam int MOD = 1 << W;
`ifdef I4003X_CP_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1, cp = 1'b0, din = 1'b0, dir = 1'b0;
    logic         load = 1'b0, burst = 1'b0, e = 1'b1;
    logic [W-1:0] d = '0;
    logic [3:0]   blen = '0;
    logic [W-1:0] q;
    logic         so, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model state: register as an integer, burst as remaining count
    int m_q = 0, m_rem = 0;
    bit m_busy = 0, m_done = 0, m_cpprev = 0, m_s1 = 0, m_s2 = 0;

    i4003x #(.WIDTH(W)) dut (
        .CLK_i(clk), .RST_i(rst), .CP_i(cp), .DATA_IN_i(din), .DIR_i(dir),
        .LOAD_i(load), .D_i(d), .BURST_i(burst), .BURST_LEN_i(blen), .E_i(e),
        .Q_o(q), .SERIAL_OUT_o(so), .BUSY_o(busy), .DONE_o(done)
    );

    always #5 clk = ~clk;

    function automatic int shifted(input int v, input bit dr, input bit bi);
        if (dr) return v / 2 + (bi ? MOD / 2 : 0);
        else    return (v * 2 + (bi ? 1 : 0)) % MOD;
    endfunction

    function automatic int exp_q();
        return e ? m_q : 0;
    endfunction

    function automatic bit exp_so();
        return dir ? bit'(m_q % 2) : bit'((m_q / (MOD / 2)) % 2);
    endfunction

    // Advance model by the rules for the coming edge, then clock the DUT
    task automatic step();
        int nq, nrem;
        bit nbusy, ndone, ncp, ns1, ns2, cps, edg;
        cps = (SYNC_LAT != 0) ? m_s2 : cp;
        edg = cps && !m_cpprev;
        nq = m_q; nrem = m_rem; nbusy = m_busy; ndone = 0;
        ncp = cps; ns1 = cp; ns2 = m_s1;
        if (rst) begin
            nq = 0; nrem = 0; nbusy = 0; ncp = 0; ns1 = 0; ns2 = 0;
        end else if (load) begin
            nq = int'(d); nrem = 0; nbusy = 0;
        end else if (m_busy) begin
            nq = shifted(m_q, dir, din);
            nrem = m_rem - 1;
            if (nrem == 0) begin nbusy = 0; ndone = 1; end
        end else if (burst) begin
            if (blen == 0) ndone = 1;
            else begin nbusy = 1; nrem = int'(blen); end
        end else if (edg) begin
            nq = shifted(m_q, dir, din);
        end
        @(posedge clk);
        #1;
        m_q = nq; m_rem = nrem; m_busy = nbusy; m_done = ndone;
        m_cpprev = ncp; m_s1 = ns1; m_s2 = ns2;
    endtask

    task automatic pulse_cp();
        cp = 1'b1; step();
        cp = 1'b0; step();
        repeat (SYNC_LAT) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        checks++; if (q !== 10'h000 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_initial q=%h so=%b busy=%b done=%b want 000/0/0/0", q, so, busy, done);
        end
        rst = 1'b0;
        load = 1'b1; d = W'($urandom_range(1, MOD - 1)); step(); load = 1'b0;
        burst = 1'b1; blen = 4'd7; step(); burst = 1'b0; step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (q !== 10'h000 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_midburst q=%h so=%b busy=%b done=%b want 000/0/0/0", q, so, busy, done);
        end
        step();
        checks++; if (done !== 1'b0) begin
            failures++; $display("FAIL reset_no_done done=%b want 0", done);
        end
    endtask

    task automatic test_serial_shift();
        logic [9:0] pat;
        pat = 10'b1011001011;
        dir = 1'b0; e = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            din = pat[i];
            pulse_cp();
        end
        checks++; if (q !== 10'h2CB || so !== 1'b1) begin
            failures++; $display("FAIL shift_dir0 q=%h so=%b want 2cb/1", q, so);
        end
        e = 1'b0; #1;
        checks++; if (q !== 10'h000 || so !== 1'b1) begin
            failures++; $display("FAIL enable_off q=%h so=%b want 000/1", q, so);
        end
        e = 1'b1; #1;
        checks++; if (q !== 10'h2CB) begin
            failures++; $display("FAIL enable_on q=%h want 2cb", q);
        end
    endtask

    task automatic test_dir1();
        load = 1'b1; d = 10'h201; step(); load = 1'b0;
        dir = 1'b1; #1;
        checks++; if (so !== 1'b1) begin
            failures++; $display("FAIL dir1_serial_after_load so=%b want 1", so);
        end
        din = 1'b0; pulse_cp();
        checks++; if (q !== 10'h100 || so !== 1'b0) begin
            failures++; $display("FAIL shift_dir1 q=%h so=%b want 100/0", q, so);
        end
        dir = 1'b0;
    endtask

    task automatic test_burst();
        int busy_cnt, done_cnt;
        load = 1'b1; d = 10'h000; step(); load = 1'b0;
        dir = 1'b0; din = 1'b1;
        burst = 1'b1; blen = 4'd4; step(); burst = 1'b0;
        busy_cnt = busy ? 1 : 0; done_cnt = done ? 1 : 0;
        cp = 1'b1; step(); busy_cnt += busy ? 1 : 0; done_cnt += done ? 1 : 0;
        cp = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(); busy_cnt += busy ? 1 : 0; done_cnt += done ? 1 : 0;
        end
        checks++; if (busy_cnt != 4) begin
            failures++; $display("FAIL burst_busy_cycles got=%0d want 4", busy_cnt);
        end
        checks++; if (done_cnt != 1) begin
            failures++; $display("FAIL burst_done_pulses got=%0d want 1", done_cnt);
        end
        checks++; if (q !== 10'h00F) begin
            failures++; $display("FAIL burst_result q=%h want 00f", q);
        end
        din = 1'b0;
    endtask

    task automatic test_load_abort();
        burst = 1'b1; blen = 4'd6; step(); burst = 1'b0;
        step(); step();
        load = 1'b1; d = 10'h155; step(); load = 1'b0;
        checks++; if (q !== 10'h155 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL load_abort q=%h busy=%b done=%b want 155/0/0", q, busy, done);
        end
        step();
        checks++; if (done !== 1'b0 || q !== 10'h155) begin
            failures++; $display("FAIL load_abort_after q=%h done=%b want 155/0", q, done);
        end
        burst = 1'b1; blen = 4'd0; step(); burst = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 10'h155) begin
            failures++; $display("FAIL burst_len0 q=%h busy=%b done=%b want 155/0/1", q, busy, done);
        end
        step();
        checks++; if (done !== 1'b0 || q !== 10'h155) begin
            failures++; $display("FAIL burst_len0_after q=%h done=%b want 155/0", q, done);
        end
    endtask

    task automatic test_cp_latency();
        int k;
        load = 1'b1; d = 10'h000; step(); load = 1'b0;
        dir = 1'b0; din = 1'b1; cp = 1'b1;
        k = 0;
        while (q === 10'h000 && k < 8) begin
            step(); k++;
        end
        cp = 1'b0;
        checks++; if (k != 1 + SYNC_LAT || q !== 10'h001) begin
            failures++; $display("FAIL cp_latency cycles=%0d q=%h want %0d/001", k, q, 1 + SYNC_LAT);
        end
        step(); step(); step();
        din = 1'b0;
    endtask

    task automatic test_reset_cp_high();
        rst = 1'b1; cp = 1'b1; din = 1'b1; dir = 1'b0; step();
        rst = 1'b0;
        repeat (1 + SYNC_LAT) step();
        checks++; if (q !== 10'h001) begin
            failures++; $display("FAIL cp_high_release q=%h want 001", q);
        end
        step(); step();
        checks++; if (q !== 10'h001) begin
            failures++; $display("FAIL cp_high_single_shift q=%h want 001", q);
        end
        cp = 1'b0; din = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 5);
            burst = ($urandom_range(0, 99) < 12);
            blen  = 4'($urandom_range(0, 15));
            d     = W'($urandom_range(0, MOD - 1));
            cp    = 1'($urandom_range(0, 1));
            din   = 1'($urandom_range(0, 1));
            dir   = ($urandom_range(0, 99) < 20) ? ~dir : dir;
            e     = ($urandom_range(0, 99) < 85);
            step();
            checks++;
            if (q !== W'(exp_q()) || so !== exp_so() || busy !== m_busy || done !== m_done) begin
                failures++;
                if (bad < 10) $display("FAIL random_cycle%0d q=%h so=%b busy=%b done=%b want %h/%b/%b/%b",
                                       i, q, so, busy, done, W'(exp_q()), exp_so(), m_busy, m_done);
                bad++;
            end
        end
        rst = 1'b0; load = 1'b0; burst = 1'b0; cp = 1'b0; e = 1'b1;
    endtask

    initial begin
        test_reset();
        test_serial_shift();
        test_dir1();
        test_burst();
        test_load_abort();
        test_cp_latency();
        test_reset_cp_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
